// File: rtl/dac_serial_model.sv
// Serial-input multi-channel DAC model: framed SCLK/SYNC_b/DIN decode, double-buffered channels, LDAC modes, daisy-chain DOUT.
// Define DAC_FRAME_CHECK_EN to commit frames on SYNC_b rise and flag malformed frames on FRAME_ERR.
module dac_serial_model #(
  parameter int CHANNELS = 8,
  parameter int RES_BITS = 10,
  parameter int FRAME_W  = 16
) (
  input  logic                         SCLK,
  input  logic                         RESET_b,
  input  logic                         SYNC_b,
  input  logic                         DIN,
  input  logic                         LDAC_b,
  output logic                         DOUT,
  output logic                         FRAME_ERR,
  output logic [5:0]                   CFG,
  output logic [CHANNELS-1:0]          PD,
  output logic [CHANNELS*RES_BITS-1:0] VOUT
);

  // mode_q | meaning
  // 0      | transparent: dacregs follow inregs on every edge
  // 1      | hardware: dacregs load when LDAC_b falls (ldac_q=1, LDAC_b=0)
  // 2      | single-shot: dacregs load on the next edge, then mode becomes 1
  localparam logic [1:0] MODE_TRANSP = 2'd0;
  localparam logic [1:0] MODE_HW     = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

  localparam int ADDR_W = $clog2(CHANNELS);
  localparam int CW     = $clog2(FRAME_W + 2);
  localparam logic [ADDR_W:0] CH_LIM = (ADDR_W + 1)'(CHANNELS);
`ifdef DAC_FRAME_CHECK_EN
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_W);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_W + 1);
`else
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_W - 1);
`endif

  logic [FRAME_W-1:0]  sh_q, sh_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic                ldac_q;
  logic [1:0]          mode_q, mode_d;
  logic [5:0]          cfg_q, cfg_d;
  logic [CHANNELS-1:0] pd_q, pd_d;
  logic [RES_BITS-1:0] inreg_q  [CHANNELS];
  logic [RES_BITS-1:0] inreg_d  [CHANNELS];
  logic [RES_BITS-1:0] dacreg_q [CHANNELS];
  logic [RES_BITS-1:0] dacreg_d [CHANNELS];

  logic               commit;
  logic               load;
  logic [FRAME_W-1:0] frame;
  logic [FRAME_W-1:0] shifted;
  logic [ADDR_W-1:0]  addr;
`ifdef DAC_FRAME_CHECK_EN
  logic               ferr_q, ferr_d;
`endif

  always_comb begin
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    armed_d  = armed_q | SYNC_b;
    mode_d   = mode_q;
    cfg_d    = cfg_q;
    pd_d     = pd_q;
    inreg_d  = inreg_q;
    dacreg_d = dacreg_q;
    commit   = 1'b0;
    load     = 1'b0;
    frame    = sh_q;
    shifted  = {sh_q[FRAME_W-2:0], DIN};
    addr     = frame[FRAME_W-2 -: ADDR_W];
`ifdef DAC_FRAME_CHECK_EN
    ferr_d   = 1'b0;
`endif

    // Loads see the pre-commit inregs; a control reset below overrides them.
    case (mode_q)
      MODE_TRANSP: load = 1'b1;
      MODE_HW:     load = ldac_q & ~LDAC_b;
      MODE_SINGLE: begin
        load   = 1'b1;
        mode_d = MODE_HW;
      end
      default:     load = 1'b0;
    endcase
    if (load) dacreg_d = inreg_q;

`ifdef DAC_FRAME_CHECK_EN
    if (SYNC_b) begin
      cnt_d = '0;
      if (cnt_q == CNT_FULL) commit = 1'b1;
      else if (cnt_q != '0)  ferr_d = 1'b1;
    end else if (armed_q) begin
      sh_d = shifted;
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
    end
`else
    if (SYNC_b) begin
      cnt_d = '0;
    end else if (armed_q) begin
      sh_d = shifted;
      if (cnt_q == CNT_LAST) begin
        commit = 1'b1;
        frame  = shifted;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
`endif

    if (commit) begin
      addr = frame[FRAME_W-2 -: ADDR_W];
      if (!frame[FRAME_W-1]) begin
        if ({1'b0, addr} < CH_LIM) inreg_d[addr] = frame[FRAME_W-2-ADDR_W -: RES_BITS];
      end else begin
        case (frame[FRAME_W-2 -: 2])
          2'b00: cfg_d = frame[5:0];
          2'b01: if (frame[1:0] != 2'b11) mode_d = frame[1:0];
          2'b10: pd_d = frame[CHANNELS-1:0];
          default: begin
            for (int i = 0; i < CHANNELS; i++) begin
              inreg_d[i]  = '0;
              dacreg_d[i] = '0;
            end
            if (frame[0]) begin
              cfg_d  = '0;
              pd_d   = '1;
              mode_d = MODE_TRANSP;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge SCLK) begin
    if (!RESET_b) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      ldac_q  <= 1'b1;
      mode_q  <= MODE_TRANSP;
      cfg_q   <= '0;
      pd_q    <= '1;
      for (int i = 0; i < CHANNELS; i++) begin
        inreg_q[i]  <= '0;
        dacreg_q[i] <= '0;
      end
    end else begin
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      ldac_q   <= LDAC_b;
      mode_q   <= mode_d;
      cfg_q    <= cfg_d;
      pd_q     <= pd_d;
      inreg_q  <= inreg_d;
      dacreg_q <= dacreg_d;
    end
  end

`ifdef DAC_FRAME_CHECK_EN
  always_ff @(posedge SCLK) begin
    if (!RESET_b) ferr_q <= 1'b0;
    else          ferr_q <= ferr_d;
  end
  assign FRAME_ERR = ferr_q;
`else
  assign FRAME_ERR = 1'b0;
`endif

  assign DOUT = sh_q[FRAME_W-1];
  assign CFG  = cfg_q;
  assign PD   = pd_q;

  // Powered-down channels float their outputs.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_vout
    assign VOUT[g*RES_BITS +: RES_BITS] = pd_q[g] ? {RES_BITS{1'bz}} : dacreg_q[g];
  end

endmodule
